// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM modulator/decoder pair: tick-grid sizing,
// counter widths and the measurement FSM state type.
package pwm_pkg;

  localparam int RES    = 8;
  localparam int PERIOD = 1 << RES;
  localparam int HI_W   = RES + 1;
  localparam int PER_W  = RES + 2;

  typedef enum logic {
    UNARMED = 1'b0,
    MEASURE = 1'b1
  } meas_state_t;

  // Master-clock cycles per tick minus one; both modulator and decoder must agree.
  function automatic int calc_div_n(input int fclkm, input int fs, input int res);
    int q;
    q = fclkm / (fs * (1 << res));
    return (q >= 1) ? q - 1 : 0;
  endfunction

endpackage

// File: rtl/pwm_tick_prescaler.sv
// Divides the master clock down to the PWM tick grid: tick is high for one
// clk every div_n+1 clk.
module pwm_tick_prescaler #(
  parameter int div_n = 5
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (div_n > 0) ? $clog2(div_n + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(div_n);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_decoder.sv
// Recovers the duty value of a PWM stream by counting high ticks between rising
// edges. d_valid/err are one-clk strobes with no back-pressure: a consumer must
// take d_out in the cycle d_valid is high; err never coincides with d_valid.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int res   = RES,
  parameter int fclkm = 16000000,
  parameter int fs    = 10000,
  parameter int tol   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pwm_in,
  output logic [res-1:0] d_out,
  output logic           d_valid,
  output logic           locked,
  output logic           err,
  output meas_state_t    state_dbg
);

  localparam int PERIOD_I = 1 << res;
  localparam int HW       = res + 1;
  localparam int PW       = res + 2;
  localparam int DIV_N    = calc_div_n(fclkm, fs, res);

  localparam logic [PW-1:0]  PER_ONE = PW'(1);
  localparam logic [PW-1:0]  PER_NOM = PW'(PERIOD_I);
  localparam logic [PW-1:0]  PER_TMO = PW'(2 * PERIOD_I);
  localparam logic [PW-1:0]  PER_MAX = '1;
  localparam logic [HW-1:0]  HI_ONE  = HW'(1);
  localparam logic [HW-1:0]  HI_MAX  = '1;
  localparam logic [res-1:0] D_MAX   = '1;

  logic tick;
  logic sync1, s, s_prev;
  logic [PW-1:0] per_cnt, per_inc;
  logic [HW-1:0] hi_cnt, hi_inc;
  logic [res-1:0] hi_clip;
  logic rise, in_tol;
  int per_dev;
  meas_state_t state, state_d;

  logic s_prev_d, valid_d, err_d, locked_d;
  logic [PW-1:0] per_d;
  logic [HW-1:0] hi_d;
  logic [res-1:0] dout_d;

  pwm_tick_prescaler #(.div_n(DIV_N)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      s     <= sync1;
    end
  end

  assign rise    = s & ~s_prev;
  assign per_inc = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PER_ONE;
  assign hi_inc  = (s && hi_cnt != HI_MAX) ? hi_cnt + HI_ONE : hi_cnt;
  assign hi_clip = hi_cnt[res] ? D_MAX : hi_cnt[res-1:0];
  assign per_dev = int'({1'b0, per_cnt}) - PERIOD_I;
  assign in_tol  = (per_dev <= tol) && (per_dev >= -tol);

  always_comb begin
    state_d  = state;
    s_prev_d = s_prev;
    per_d    = per_cnt;
    hi_d     = hi_cnt;
    dout_d   = d_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    locked_d = locked;
    if (tick) begin
      s_prev_d = s;
      if (rise) begin
        per_d = PER_ONE;
        hi_d  = HI_ONE;
        case (state)
          UNARMED: state_d = MEASURE;
          MEASURE: begin
            if (in_tol) begin
              dout_d   = hi_clip;
              valid_d  = 1'b1;
              locked_d = 1'b1;
            end else begin
              err_d    = 1'b1;
              locked_d = 1'b0;
            end
          end
          default: state_d = UNARMED;
        endcase
      end else begin
        per_d = per_inc;
        hi_d  = hi_inc;
        // Line stuck for two nominal periods: report the constant level.
        if (per_inc == PER_TMO) begin
          dout_d   = s ? D_MAX : '0;
          valid_d  = 1'b1;
          locked_d = 1'b0;
          state_d  = UNARMED;
          per_d    = PER_NOM;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= UNARMED;
      s_prev  <= 1'b0;
      per_cnt <= '0;
      hi_cnt  <= '0;
      d_out   <= '0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      locked  <= 1'b0;
    end else begin
      state   <= state_d;
      s_prev  <= s_prev_d;
      per_cnt <= per_d;
      hi_cnt  <= hi_d;
      d_out   <= dout_d;
      d_valid <= valid_d;
      err     <= err_d;
      locked  <= locked_d;
    end
  end

  assign state_dbg = state;

endmodule
